// File: rtl/pkt_pkg.sv
// Word layout and tag encodings for the 134-bit packet word shared with the packet processor.
package pkt_pkg;

    localparam int PKT_W   = 134;
    localparam int PAY_W   = 128;
    localparam int LEN_LSB = 128;
    localparam int TAG_LSB = 132;

    localparam logic [1:0] TAG_HEAD = 2'b01;
    localparam logic [1:0] TAG_BODY = 2'b11;
    localparam logic [1:0] TAG_TAIL = 2'b10;

    function automatic logic [PKT_W-1:0] mk_word(input logic [1:0] tag,
                                                 input logic [3:0] len,
                                                 input logic [PAY_W-1:0] pay);
        logic [PKT_W-1:0] w;
        w = '0;
        w[TAG_LSB +: 2]  = tag;
        w[LEN_LSB +: 4]  = len;
        w[PAY_W-1:0]     = pay;
        return w;
    endfunction

endpackage

// File: rtl/pkt_rx_pack_if.sv
// Byte-wide receive stream in, packed words and software counters out.
interface pkt_rx_pack_if;

    logic                     rx_valid;
    logic [7:0]               rx_data;
    logic                     rx_last;
    logic                     rx_err;
    logic                     data_out_valid;
    logic [pkt_pkg::PKT_W-1:0] data_out;
    logic [31:0]              pkt_cnt;
    logic [15:0]              drop_cnt;
    logic [15:0]              err_cnt;

    modport master (
        output rx_valid, rx_data, rx_last, rx_err,
        input  data_out_valid, data_out, pkt_cnt, drop_cnt, err_cnt
    );

    modport slave (
        input  rx_valid, rx_data, rx_last, rx_err,
        output data_out_valid, data_out, pkt_cnt, drop_cnt, err_cnt
    );

endinterface

// File: rtl/pkt_rx_pack.sv
// Packs a byte stream into head/body/tail words; drops runts and frames gone bad before the head leaves.
// Words leave one cycle after the byte completing the next word (tail one cycle later); no backpressure.
module pkt_rx_pack
    import pkt_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    pkt_rx_pack_if.slave  bus
);

    logic [PAY_W-1:0] acc_q,  acc_d;
    logic [PAY_W-1:0] hold_q, hold_d;
    logic [PAY_W-1:0] tail_q, tail_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       tail_len_q, tail_len_d;
    logic             hold_v_q, hold_v_d;
    logic             hold_first_q, hold_first_d;
    logic             tail_v_q, tail_v_d;
    logic             tail_bad_q, tail_bad_d;
    logic             bad_q, bad_d;
    logic             head_sent_q, head_sent_d;
    logic             out_vld_q, out_vld_d;
    logic [PKT_W-1:0] out_dat_q, out_dat_d;
    logic [31:0]      pkt_cnt_q, pkt_cnt_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic [15:0]      err_cnt_q, err_cnt_d;

    logic [PAY_W-1:0] word;
    logic [6:0]       pos;
    logic             bad_now;
    logic             word_done;

    always_comb begin
        acc_d        = acc_q;
        hold_d       = hold_q;
        tail_d       = tail_q;
        idx_d        = idx_q;
        tail_len_d   = tail_len_q;
        hold_v_d     = hold_v_q;
        hold_first_d = hold_first_q;
        tail_v_d     = tail_v_q;
        tail_bad_d   = tail_bad_q;
        bad_d        = bad_q;
        head_sent_d  = head_sent_q;
        out_vld_d    = 1'b0;
        out_dat_d    = '0;
        pkt_cnt_d    = pkt_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        err_cnt_d    = err_cnt_q;

        // Byte i of the word lands at bit 8*(15-i); the accumulator is zero at index 0,
        // so short tails come out zero-padded.
        pos       = {~idx_q, 3'b000};
        word      = acc_q | ({120'd0, bus.rx_data} << pos);
        bad_now   = bad_q | (bus.rx_valid & bus.rx_err);
        word_done = bus.rx_valid & (bus.rx_last | (idx_q == 4'hf));

        if (tail_v_q) begin
            out_vld_d = 1'b1;
            out_dat_d = mk_word(TAG_TAIL, tail_len_q, tail_q);
            tail_v_d  = 1'b0;
            if (pkt_cnt_q != '1)
                pkt_cnt_d = pkt_cnt_q + 32'd1;
            if (tail_bad_q && err_cnt_q != '1)
                err_cnt_d = err_cnt_q + 16'd1;
        end

        if (bus.rx_valid && !word_done) begin
            acc_d = word;
            idx_d = idx_q + 4'd1;
            bad_d = bad_now;
        end else if (word_done) begin
            acc_d = '0;
            idx_d = '0;
            bad_d = bad_now;
            if (bad_now && !head_sent_q) begin
                // Frame is lost before anything left: suppress output, count at frame end.
                if (bus.rx_last && drop_cnt_q != '1)
                    drop_cnt_d = drop_cnt_q + 16'd1;
            end else if (!bus.rx_last) begin
                if (hold_v_q) begin
                    out_vld_d   = 1'b1;
                    out_dat_d   = mk_word(hold_first_q ? TAG_HEAD : TAG_BODY, 4'hf, hold_q);
                    head_sent_d = 1'b1;
                end
                hold_d       = word;
                hold_v_d     = 1'b1;
                hold_first_d = !hold_v_q;
            end else if (hold_v_q) begin
                out_vld_d  = 1'b1;
                out_dat_d  = mk_word(hold_first_q ? TAG_HEAD : TAG_BODY, 4'hf, hold_q);
                tail_d     = word;
                tail_v_d   = 1'b1;
                tail_len_d = idx_q;
                tail_bad_d = bad_now;
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end

            if (bus.rx_last) begin
                hold_v_d    = 1'b0;
                head_sent_d = 1'b0;
                bad_d       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            hold_q       <= '0;
            tail_q       <= '0;
            idx_q        <= '0;
            tail_len_q   <= '0;
            hold_v_q     <= 1'b0;
            hold_first_q <= 1'b0;
            tail_v_q     <= 1'b0;
            tail_bad_q   <= 1'b0;
            bad_q        <= 1'b0;
            head_sent_q  <= 1'b0;
            out_vld_q    <= 1'b0;
            out_dat_q    <= '0;
            pkt_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            err_cnt_q    <= '0;
        end else begin
            acc_q        <= acc_d;
            hold_q       <= hold_d;
            tail_q       <= tail_d;
            idx_q        <= idx_d;
            tail_len_q   <= tail_len_d;
            hold_v_q     <= hold_v_d;
            hold_first_q <= hold_first_d;
            tail_v_q     <= tail_v_d;
            tail_bad_q   <= tail_bad_d;
            bad_q        <= bad_d;
            head_sent_q  <= head_sent_d;
            out_vld_q    <= out_vld_d;
            out_dat_q    <= out_dat_d;
            pkt_cnt_q    <= pkt_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.data_out_valid = out_vld_q;
    assign bus.data_out       = out_dat_q;
    assign bus.pkt_cnt        = pkt_cnt_q;
    assign bus.drop_cnt       = drop_cnt_q;
    assign bus.err_cnt        = err_cnt_q;

endmodule
